// File: rtl/md_unit.sv
// Multiply/divide unit driving the HI/LO registers. It uses a fixed-latency busy window.
// Results are computed at acceptance and committed to HI/LO when the window closes.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        EXStart,
    input  logic [2:0]  EXMDOp,
    input  logic [31:0] EXA,
    input  logic [31:0] EXB,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [31:0]    ph, pl;

    logic [63:0]    prod_u, prod_s;
    logic           a_neg, b_neg, sdiv;
    logic [31:0]    num, den, q, r;
    logic [31:0]    nxt_ph, nxt_pl;
    logic [CW-1:0]  nxt_cnt;

    // Signed division runs on magnitudes so 0x80000000 / -1 needs no special case.
    always_comb begin
        prod_u = {32'h0, EXA} * {32'h0, EXB};
        prod_s = {{32{EXA[31]}}, EXA} * {{32{EXB[31]}}, EXB};
        sdiv   = (EXMDOp == 3'd2);
        a_neg  = sdiv & EXA[31];
        b_neg  = sdiv & EXB[31];
        num    = a_neg ? -EXA : EXA;
        den    = b_neg ? -EXB : EXB;
        if (den == '0) begin
            q = '0;
            r = '0;
        end else begin
            q = num / den;
            r = num % den;
        end
        nxt_ph  = HI;
        nxt_pl  = LO;
        nxt_cnt = CW'(DIV_CYCLES);
        case (EXMDOp)
            3'd0: begin
                nxt_ph  = prod_s[63:32];
                nxt_pl  = prod_s[31:0];
                nxt_cnt = CW'(MULT_CYCLES);
            end
            3'd1: begin
                nxt_ph  = prod_u[63:32];
                nxt_pl  = prod_u[31:0];
                nxt_cnt = CW'(MULT_CYCLES);
            end
            3'd2, 3'd3: begin
                if (EXB != '0) begin
                    nxt_pl = (a_neg ^ b_neg) ? -q : q;
                    nxt_ph = a_neg ? -r : r;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state <= IDLE;
            cnt   <= '0;
            ph    <= '0;
            pl    <= '0;
            HI    <= '0;
            LO    <= '0;
            Busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (EXStart) begin
                        case (EXMDOp)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                ph    <= nxt_ph;
                                pl    <= nxt_pl;
                                cnt   <= nxt_cnt;
                                Busy  <= 1'b1;
                                state <= RUN;
                            end
                            3'd4: HI <= EXA;
                            3'd5: LO <= EXA;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        HI    <= ph;
                        LO    <= pl;
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases with literal expectations and randomized traffic.
// An arithmetic reference model is checked against the DUT on every cycle.
module tb_md_unit;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        EXStart;
    logic [2:0]  EXMDOp;
    logic [31:0] EXA, EXB;
    logic        Busy;
    logic [31:0] HI, LO;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .CLK(CLK), .RSTn(RSTn), .EXStart(EXStart), .EXMDOp(EXMDOp),
        .EXA(EXA), .EXB(EXB), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 CLK = ~CLK;

    // Reference model: remaining busy cycles plus the result that is waiting to be committed.
    bit          m_busy;
    int          m_left;
    logic [31:0] m_hi, m_lo, m_rhi, m_rlo;

    always @(posedge CLK) begin
        longint          ps;
        longint unsigned pu;
        int              sa, sb;
        if (!RSTn) begin
            m_busy = 0; m_left = 0; m_hi = 0; m_lo = 0; m_rhi = 0; m_rlo = 0;
            chk_en = 1'b1;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_hi = m_rhi; m_lo = m_rlo; m_busy = 0;
            end
        end else if (EXStart) begin
            case (EXMDOp)
                3'd0: begin
                    ps = longint'($signed(EXA)) * longint'($signed(EXB));
                    m_rhi = ps[63:32]; m_rlo = ps[31:0];
                    m_left = MC; m_busy = 1;
                end
                3'd1: begin
                    pu = {32'h0, EXA} * {32'h0, EXB};
                    m_rhi = pu[63:32]; m_rlo = pu[31:0];
                    m_left = MC; m_busy = 1;
                end
                3'd2: begin
                    m_rhi = m_hi; m_rlo = m_lo;
                    if (EXB == 0) ;
                    else if (EXA == 32'h8000_0000 && EXB == 32'hFFFF_FFFF) begin
                        m_rlo = 32'h8000_0000; m_rhi = 0;
                    end else begin
                        sa = EXA; sb = EXB;
                        m_rlo = sa / sb; m_rhi = sa % sb;
                    end
                    m_left = DC; m_busy = 1;
                end
                3'd3: begin
                    m_rhi = m_hi; m_rlo = m_lo;
                    if (EXB != 0) begin
                        m_rlo = EXA / EXB; m_rhi = EXA % EXB;
                    end
                    m_left = DC; m_busy = 1;
                end
                3'd4: m_hi = EXA;
                3'd5: m_lo = EXA;
                default: ;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("model_busy", {31'b0, Busy}, {31'b0, m_busy});
            check("model_hi", HI, m_hi);
            check("model_lo", LO, m_lo);
        end
    end

    task automatic cyc(input bit rst, input bit st, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
        RSTn = rst; EXStart = st; EXMDOp = op; EXA = a; EXB = b;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        cyc(1, 0, 3'd0, $urandom, $urandom);
    endtask

    // Idles until Busy drops; reports how many busy cycles were seen.
    task automatic wait_idle(input string name, input int exp_len);
        int n = 0;
        while (Busy === 1'b1 && n < 40) begin
            n++;
            idle();
        end
        check(name, n, exp_len);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [2:0]  op;
        cyc(0, 1, 3'd4, 32'h1234, 0);
        cyc(0, 0, 3'd0, 0, 0);
        check("rst_busy", {31'b0, Busy}, 0);
        check("rst_hi", HI, 0);
        check("rst_lo", LO, 0);

        cyc(1, 1, 3'd0, 32'hFFFF_FFFE, 3);
        check("first_accept", {31'b0, Busy}, 1);
        wait_idle("mult_len", 5);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFA);
        cyc(1, 1, 3'd1, 32'hFFFF_FFFE, 3);
        wait_idle("multu_len", 5);
        check("multu_hi", HI, 32'h0000_0002);
        check("multu_lo", LO, 32'hFFFF_FFFA);

        cyc(1, 1, 3'd2, 32'hFFFF_FFF9, 2);
        wait_idle("div_len", 10);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);
        cyc(1, 1, 3'd3, 7, 2);
        wait_idle("divu_len", 10);
        check("divu_lo", LO, 3);
        check("divu_hi", HI, 1);

        cyc(1, 1, 3'd4, 32'h11, 0);
        cyc(1, 1, 3'd5, 32'h22, 0);
        cyc(1, 1, 3'd2, 32'h99, 0);
        wait_idle("div0_len", 10);
        check("div0_hi", HI, 32'h11);
        check("div0_lo", LO, 32'h22);
        cyc(1, 1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("ovf_len", 10);
        check("ovf_lo", LO, 32'h8000_0000);
        check("ovf_hi", HI, 0);

        cyc(1, 1, 3'd4, 32'hDEAD_BEEF, 0);
        check("mthi_hi", HI, 32'hDEAD_BEEF);
        check("mthi_busy", {31'b0, Busy}, 0);
        cyc(1, 1, 3'd5, 32'h1234_5678, 0);
        check("mtlo_lo", LO, 32'h1234_5678);
        check("mtlo_busy", {31'b0, Busy}, 0);

        cyc(1, 1, 3'd0, 3, 4);
        cyc(1, 1, 3'd5, 32'h55, 0);
        cyc(1, 1, 3'd2, 100, 7);
        wait_idle("ign_len", 3);
        check("ign_hi", HI, 0);
        check("ign_lo", LO, 12);
        cyc(1, 1, 3'd2, 100, 7);
        check("b2b_busy", {31'b0, Busy}, 1);
        wait_idle("b2b_len", 10);
        check("b2b_lo", LO, 14);
        check("b2b_hi", HI, 2);

        cyc(1, 1, 3'd6, 32'hAAAA, 0);
        check("rsv_busy", {31'b0, Busy}, 0);
        check("rsv_hi", HI, 2);

        cyc(1, 1, 3'd2, 1000, 3);
        idle();
        idle();
        cyc(0, 1, 3'd4, 32'h77, 0);
        check("abort_busy", {31'b0, Busy}, 0);
        check("abort_hi", HI, 0);
        check("abort_lo", LO, 0);
        for (int i = 0; i < 10; i++) idle();
        check("abort_hi_after", HI, 0);
        check("abort_lo_after", LO, 0);

        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0: a = $urandom_range(0, 20);
                1: a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(1, 9);
                default: b = $urandom;
            endcase
            op = 3'($urandom_range(0, 7));
            cyc(($urandom_range(0, 80) != 0), ($urandom_range(0, 2) != 0), op, a, b);
        end
        cyc(1, 0, 3'd0, 0, 0);
        for (int i = 0; i < 12; i++) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
